fmi_tile_loader: RTL and testbench

//  Input stage of the IRB datapath: loads one input feature-map tile into RAM FMI for the expansion stage.

---
 rtl/fmi_tile_loader.sv | 171 +++++++++++++++++
 tb/tb_fmi_tile_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmi_tile_loader.sv
// rtl/fmi_tile_loader.sv - loads one input feature-map tile into RAM FMI, zero-filling pad borders
module fmi_tile_loader #(
    parameter int TIX_T      = 16,
    parameter int TIY_T      = 16,
    parameter int TIF        = 8,
    parameter int PX_W       = 16,
    parameter int SIZE_FMI_T = TIX_T * TIY_T,
    parameter int FMI_N_ELEM = SIZE_FMI_T * TIF,
    parameter int AW         = $clog2(FMI_N_ELEM)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [3:0]      cfg_nif_i,
    input  logic [4:0]      cfg_tix_i,
    input  logic [4:0]      cfg_tiy_i,
    input  logic [3:0]      cfg_pad_i,
    input  logic            s_valid_i,
    input  logic [PX_W-1:0] s_data_i,
    output logic            s_ready_o,
    output logic            ram_we_o,
    output logic [AW-1:0]   ram_addr_o,
    output logic [PX_W-1:0] ram_wdata_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [3:0]      nif_q, nif_d;
    logic [4:0]      tix_q, tix_d;
    logic [4:0]      tiy_q, tiy_d;
    logic [3:0]      pad_q, pad_d;
    logic [3:0]      c_q, c_d;
    logic [4:0]      y_q, y_d;
    logic [4:0]      x_q, x_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [PX_W-1:0] wdata_q, wdata_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [4:0]    pad_lr, pad_tb;
    logic          cfg_ok;
    logic          x_last, y_last, c_last;
    logic          pad_pos;
    logic          advance;
    logic          ready;
    logic [AW-1:0] addr_calc;

    // A tile needs at least one real data column and row between its pad borders.
    assign pad_lr = 5'(cfg_pad_i[0]) + 5'(cfg_pad_i[2]);
    assign pad_tb = 5'(cfg_pad_i[1]) + 5'(cfg_pad_i[3]);
    assign cfg_ok = (cfg_nif_i != 4'd0) && (cfg_nif_i <= 4'(TIF)) &&
                    (cfg_tix_i != 5'd0) && (cfg_tix_i <= 5'(TIX_T)) &&
                    (cfg_tiy_i != 5'd0) && (cfg_tiy_i <= 5'(TIY_T)) &&
                    (cfg_tix_i > pad_lr) && (cfg_tiy_i > pad_tb);

    assign x_last  = (x_q == tix_q - 5'd1);
    assign y_last  = (y_q == tiy_q - 5'd1);
    assign c_last  = (c_q == nif_q - 4'd1);
    assign pad_pos = (pad_q[0] && (x_q == 5'd0)) || (pad_q[2] && x_last) ||
                     (pad_q[1] && (y_q == 5'd0)) || (pad_q[3] && y_last);

    assign addr_calc = AW'(c_q) * AW'(SIZE_FMI_T) + AW'(y_q) * AW'(TIX_T) + AW'(x_q);
    assign advance   = (state_q == RUN) && (pad_pos || s_valid_i);
    assign ready     = (state_q == RUN) && !pad_pos;

    always_comb begin
        state_d = state_q;
        nif_d   = nif_q;
        tix_d   = tix_q;
        tiy_d   = tiy_q;
        pad_d   = pad_q;
        c_d     = c_q;
        y_d     = y_q;
        x_d     = x_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        nif_d   = cfg_nif_i;
                        tix_d   = cfg_tix_i;
                        tiy_d   = cfg_tiy_i;
                        pad_d   = cfg_pad_i;
                        c_d     = 4'd0;
                        y_d     = 5'd0;
                        x_d     = 5'd0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (advance) begin
                    we_d    = 1'b1;
                    addr_d  = addr_calc;
                    wdata_d = pad_pos ? '0 : s_data_i;
                    if (x_last && y_last && c_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        c_d     = 4'd0;
                        y_d     = 5'd0;
                        x_d     = 5'd0;
                    end else if (x_last) begin
                        x_d = 5'd0;
                        if (y_last) begin
                            y_d = 5'd0;
                            c_d = c_q + 4'd1;
                        end else begin
                            y_d = y_q + 5'd1;
                        end
                    end else begin
                        x_d = x_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            nif_q   <= '0;
            tix_q   <= '0;
            tiy_q   <= '0;
            pad_q   <= '0;
            c_q     <= '0;
            y_q     <= '0;
            x_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nif_q   <= nif_d;
            tix_q   <= tix_d;
            tiy_q   <= tiy_d;
            pad_q   <= pad_d;
            c_q     <= c_d;
            y_q     <= y_d;
            x_q     <= x_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // busy stays up through the done cycle, dropping on the cycle after it.
    assign busy_o      = (state_q == RUN) || done_q;
    assign s_ready_o   = ready;
    assign ram_we_o    = we_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fmi_tile_loader.sv
// tb/tb_fmi_tile_loader.sv - scoreboard bench for fmi_tile_loader
module tb_fmi_tile_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_nif;
    logic [4:0]  cfg_tix;
    logic [4:0]  cfg_tiy;
    logic [3:0]  cfg_pad;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    // {done, addr, data} of each expected RAM write, in order
    logic [27:0] sb[$];

    logic        last_ready, last_busy, last_err, last_we, last_done;
    logic        busy_at_done;
    logic        seen_done;
    int          wr_count;

    always #5 clk = ~clk;

    fmi_tile_loader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .cfg_nif_i   (cfg_nif),
        .cfg_tix_i   (cfg_tix),
        .cfg_tiy_i   (cfg_tiy),
        .cfg_pad_i   (cfg_pad),
        .s_valid_i   (s_valid),
        .s_data_i    (s_data),
        .s_ready_o   (s_ready),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    // One clock: sample outputs at negedge, score any RAM write, return 1 after posedge.
    task automatic tick();
        logic [27:0] exp_w;
        @(negedge clk);
        last_ready = s_ready;
        last_busy  = busy;
        last_err   = err;
        last_we    = ram_we;
        last_done  = done;
        if (ram_we === 1'b1) begin
            vectors++;
            wr_count++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h done=%b, expected no write", ram_addr, ram_wdata, done);
            end else begin
                exp_w = sb.pop_front();
                if ({done, ram_addr, ram_wdata} !== exp_w) begin
                    miscompares++;
                    $display("FAIL wr_seq: got done=%b addr=%0d data=%h, expected done=%b addr=%0d data=%h",
                             done, ram_addr, ram_wdata, exp_w[27], exp_w[26:16], exp_w[15:0]);
                end
            end
            if (done === 1'b1) begin
                seen_done    = 1'b1;
                busy_at_done = busy;
            end
        end else if (done !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_without_write: got done=%b we=%b, expected done only with a write", done, ram_we);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_tile(input int nif, input int tix, input int tiy, input logic [3:0] pad,
                            input logic [15:0] base, input bit rnd, input bit mid_start,
                            input int abort_after);
        logic [15:0] beats[$];
        int k = 0;
        int idx = 0;
        int cyc = 0;
        bit padp, lastp;
        int a;
        beats.delete();
        for (int c = 0; c < nif; c++)
            for (int y = 0; y < tiy; y++)
                for (int x = 0; x < tix; x++) begin
                    padp  = (pad[0] && x == 0) || (pad[2] && x == tix - 1) ||
                            (pad[1] && y == 0) || (pad[3] && y == tiy - 1);
                    lastp = (c == nif - 1) && (y == tiy - 1) && (x == tix - 1);
                    a = c * 256 + y * 16 + x;
                    if (padp) begin
                        sb.push_back({lastp, 11'(a), 16'h0000});
                    end else begin
                        sb.push_back({lastp, 11'(a), 16'(base + 16'(k))});
                        beats.push_back(16'(base + 16'(k)));
                        k++;
                    end
                end
        cfg_nif = 4'(nif);
        cfg_tix = 5'(tix);
        cfg_tiy = 5'(tiy);
        cfg_pad = pad;
        seen_done = 1'b0;
        busy_at_done = 1'b0;
        wr_count = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!seen_done && cyc < 5000) begin
            if (abort_after != 0 && wr_count >= abort_after) break;
            s_valid = (idx < beats.size()) && (!rnd || $urandom_range(0, 1) == 1);
            s_data  = (idx < beats.size()) ? beats[idx] : 16'hDEAD;
            if (mid_start && cyc == 20) begin
                start   = 1'b1;
                cfg_nif = 4'd2;
                cfg_tix = 5'd4;
                cfg_tiy = 5'd4;
                cfg_pad = 4'b1111;
            end else begin
                start = 1'b0;
            end
            tick();
            if (s_valid && last_ready) idx++;
            cyc++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (abort_after != 0) return;
        vectors++;
        if (!seen_done) begin
            miscompares++;
            $display("FAIL tile_timeout: got no done after %0d cycles, expected done", cyc);
        end
        vectors++;
        if (idx != beats.size()) begin
            miscompares++;
            $display("FAIL beats_consumed: got %0d, expected %0d", idx, beats.size());
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL writes_missing: got %0d outstanding, expected 0", sb.size());
        end
        vectors++;
        if (busy_at_done !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_at_done: got %b, expected 1", busy_at_done);
        end
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        tick();
        s_valid = 1'b0;
        vectors++;
        if (last_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL extra_beat_ready: got %b, expected 0", last_ready);
        end
        vectors++;
        if (last_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_done: got %b, expected 0", last_busy);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({ram_we, ram_addr, ram_wdata, busy, done, err, s_ready} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h busy=%b done=%b err=%b ready=%b, expected all 0",
                     ram_we, ram_addr, ram_wdata, busy, done, err, s_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_tile();
        run_tile(1, 16, 16, 4'b0000, 16'h0000, 1'b0, 1'b0, 0);
    endtask

    task automatic test_padded();
        run_tile(2, 4, 4, 4'b1111, 16'hA000, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random_valid();
        run_tile(2, 4, 4, 4'b1111, 16'hA000, 1'b1, 1'b0, 0);
    endtask

    task automatic test_invalid_cfg();
        logic [3:0]  nifs[2] = '{4'd0, 4'd1};
        logic [4:0]  tixs[2] = '{5'd16, 5'd2};
        logic [3:0]  pads[2] = '{4'b0000, 4'b0101};
        for (int i = 0; i < 2; i++) begin
            cfg_nif = nifs[i];
            cfg_tix = tixs[i];
            cfg_tiy = 5'd16;
            cfg_pad = pads[i];
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            vectors++;
            if (last_err !== 1'b1 || last_busy !== 1'b0 || last_we !== 1'b0) begin
                miscompares++;
                $display("FAIL invalid_cfg_%0d: got err=%b busy=%b we=%b, expected err=1 busy=0 we=0",
                         i, last_err, last_busy, last_we);
            end
            tick();
            vectors++;
            if (last_err !== 1'b0 || last_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL invalid_cfg_after_%0d: got err=%b busy=%b, expected 0 0", i, last_err, last_busy);
            end
        end
    endtask

    task automatic test_start_during_run();
        run_tile(1, 16, 16, 4'b0000, 16'h5000, 1'b0, 1'b1, 0);
    endtask

    task automatic test_reset_mid_tile();
        run_tile(1, 16, 16, 4'b0000, 16'h0000, 1'b0, 1'b0, 10);
        rst = 1'b1;
        tick();
        sb.delete();
        tick();
        vectors++;
        if (last_we !== 1'b0 || last_busy !== 1'b0 || last_done !== 1'b0 || last_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_tile: got we=%b busy=%b done=%b ready=%b, expected all 0",
                     last_we, last_busy, last_done, last_ready);
        end
        rst = 1'b0;
        tick();
        run_tile(2, 4, 4, 4'b1111, 16'hC000, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_nif = '0;
        cfg_tix = '0;
        cfg_tiy = '0;
        cfg_pad = '0;
        s_valid = 1'b0;
        s_data = '0;
        seen_done = 1'b0;
        busy_at_done = 1'b0;
        wr_count = 0;
        test_reset();
        test_full_tile();
        test_padded();
        test_random_valid();
        test_invalid_cfg();
        test_start_during_run();
        test_reset_mid_tile();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
